// File: rtl/mem_port_arbiter.sv
// Round-robin owner of the shared data-memory port: one grant at a time, strobe held MEM_LAT cycles,
// done pulsed the cycle after; requesters hold level requests until done (one access per MEM_LAT+2 cycles).
module mem_port_arbiter #(
   parameter int NCORES  = 4,
   parameter int AW      = 16,
   parameter int DW      = 8,
   parameter int MEM_LAT = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NCORES-1:0]    req_rd,
   input  logic [NCORES-1:0]    req_wr,
   input  logic [NCORES*AW-1:0] req_addr,
   input  logic [NCORES*DW-1:0] req_wdata,
   output logic [NCORES-1:0]    gnt,
   output logic [NCORES-1:0]    done,
   output logic [DW-1:0]        rdata,
   output logic                 busy,
   output logic                 mem_rd,
   output logic                 mem_wr,
   output logic [AW-1:0]        mem_addr,
   output logic [DW-1:0]        mem_wdata,
   input  logic [DW-1:0]        mem_rdata
);
   localparam int IW = $clog2(NCORES);
   localparam int SW = IW + 1;
   localparam int CW = $clog2(MEM_LAT + 1);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
   logic [IW-1:0]     id_q, id_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [NCORES-1:0] mask_q, mask_d;
   logic [NCORES-1:0] gnt_q, gnt_d;
   logic [NCORES-1:0] done_q, done_d;
   logic [DW-1:0]     rdata_q, rdata_d;
   logic              busy_q, busy_d;
   logic              mem_rd_q, mem_rd_d;
   logic              mem_wr_q, mem_wr_d;
   logic [AW-1:0]     mem_addr_q, mem_addr_d;
   logic [DW-1:0]     mem_wdata_q, mem_wdata_d;

   logic [NCORES-1:0] cand;
   logic [NCORES-1:0] cand_rot;
   logic [SW-1:0]     sum;
   logic              win_found;
   logic [IW-1:0]     win_id;

   // Rotate candidates so bit 0 is the core at rr_ptr; lowest set bit wins.
   assign cand     = (req_rd | req_wr) & ~mask_q;
   assign cand_rot = NCORES'({cand, cand} >> rr_ptr_q);

   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      sum       = '0;
      for (int k = NCORES - 1; k >= 0; k--) begin
         if (cand_rot[k]) begin
            sum = {1'b0, rr_ptr_q} + SW'(k);
            if (sum >= SW'(NCORES)) begin
               sum = sum - SW'(NCORES);
            end
            win_found = 1'b1;
            win_id    = sum[IW-1:0];
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      id_d        = id_q;
      cnt_d       = cnt_q;
      mask_d      = mask_q;
      gnt_d       = gnt_q;
      done_d      = done_q;
      rdata_d     = rdata_q;
      busy_d      = busy_q;
      mem_rd_d    = mem_rd_q;
      mem_wr_d    = mem_wr_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      case (state_q)
         S_IDLE: begin
            mask_d = '0;
            if (win_found) begin
               id_d        = win_id;
               gnt_d       = NCORES'(1) << win_id;
               busy_d      = 1'b1;
               mem_wr_d    = req_wr[win_id];
               mem_rd_d    = ~req_wr[win_id];
               mem_addr_d  = req_addr[win_id*AW +: AW];
               mem_wdata_d = req_wdata[win_id*DW +: DW];
               cnt_d       = '0;
               state_d     = S_ACCESS;
            end
         end
         S_ACCESS: begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(MEM_LAT - 1)) begin
               if (mem_rd_q) begin
                  rdata_d = mem_rdata;
               end
               mem_rd_d = 1'b0;
               mem_wr_d = 1'b0;
               done_d   = gnt_q;
               state_d  = S_DONE;
            end
         end
         S_DONE: begin
            done_d   = '0;
            gnt_d    = '0;
            busy_d   = 1'b0;
            rr_ptr_d = (id_q == IW'(NCORES - 1)) ? '0 : id_q + IW'(1);
            // Hide the just-served core for one IDLE cycle so its held request is not re-served.
            mask_d   = NCORES'(1) << id_q;
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         rr_ptr_q    <= '0;
         id_q        <= '0;
         cnt_q       <= '0;
         mask_q      <= '0;
         gnt_q       <= '0;
         done_q      <= '0;
         rdata_q     <= '0;
         busy_q      <= 1'b0;
         mem_rd_q    <= 1'b0;
         mem_wr_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         id_q        <= id_d;
         cnt_q       <= cnt_d;
         mask_q      <= mask_d;
         gnt_q       <= gnt_d;
         done_q      <= done_d;
         rdata_q     <= rdata_d;
         busy_q      <= busy_d;
         mem_rd_q    <= mem_rd_d;
         mem_wr_q    <= mem_wr_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   assign gnt       = gnt_q;
   assign done      = done_q;
   assign rdata     = rdata_q;
   assign busy      = busy_q;
   assign mem_rd    = mem_rd_q;
   assign mem_wr    = mem_wr_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic against a transaction-timeline model.
module tb_mem_port_arbiter;
   localparam int N  = 4;
   localparam int AW = 16;
   localparam int DW = 8;
   localparam int L  = 2;
   localparam int VW = 2*N + 3 + AW + 2*DW;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst;
   logic [N-1:0]      req_rd, req_wr;
   logic [N*AW-1:0]   req_addr;
   logic [N*DW-1:0]   req_wdata;
   logic [N-1:0]      gnt, done;
   logic [DW-1:0]     rdata, mem_wdata, mem_rdata;
   logic              busy, mem_rd, mem_wr;
   logic [AW-1:0]     mem_addr;

   mem_port_arbiter #(.NCORES(N), .AW(AW), .DW(DW), .MEM_LAT(L)) dut (
      .clk(clk), .rst(rst), .req_rd(req_rd), .req_wr(req_wr), .req_addr(req_addr),
      .req_wdata(req_wdata), .gnt(gnt), .done(done), .rdata(rdata), .busy(busy),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   // Memory returns real data only on the last cycle of a read strobe.
   logic [7:0] mem [256];
   int rd_run = 0;
   always @(posedge clk) rd_run <= mem_rd ? rd_run + 1 : 0;
   assign mem_rdata = (mem_rd && rd_run == L - 1) ? mem[mem_addr[7:0]] : ~mem[mem_addr[7:0]];

   logic [VW-1:0] obs, exp_vec;
   assign obs = {gnt, done, busy, mem_rd, mem_wr, mem_addr, mem_wdata, rdata};

   int checks = 0;
   int failures = 0;

   // Timeline model: each access decided in IDLE cycle s occupies s+1..s+L+1.
   int          cyc = 0;
   int          next_idle = 0;
   int          rr = 0;
   int          mask_cyc = -1;
   int          mask_id = 0;
   bit          a_valid = 1'b0;
   int          a_start = 0;
   int          a_id = 0;
   bit          a_wr = 1'b0;
   logic [7:0]  a_rdata = '0;
   logic [7:0]  m_rdata = '0;
   logic [15:0] m_addr = '0;
   logic [7:0]  m_wdata = '0;

   task automatic step();
      int win, idx, d;
      logic [N-1:0] e_gnt, e_done;
      logic e_busy, e_rd, e_wr;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_wdata, e_rdata;
      win = -1;
      if (rst) begin
         a_valid = 1'b0; rr = 0; mask_cyc = -1;
         m_rdata = '0; m_addr = '0; m_wdata = '0;
         next_idle = cyc + 1;
      end else if (cyc >= next_idle) begin
         for (int k = 0; k < N; k++) begin
            idx = (rr + k) % N;
            if (win < 0 && (req_rd[idx] || req_wr[idx]) && !(cyc == mask_cyc && idx == mask_id))
               win = idx;
         end
         if (win >= 0) begin
            if (a_valid && !a_wr) m_rdata = a_rdata;
            a_valid = 1'b1; a_start = cyc; a_id = win; a_wr = req_wr[win];
            m_addr  = req_addr[win*AW +: AW];
            m_wdata = req_wdata[win*DW +: DW];
            a_rdata = mem[m_addr[7:0]];
            next_idle = cyc + L + 2;
            rr = (win + 1) % N;
            mask_cyc = cyc + L + 2;
            mask_id = win;
         end
      end
      d = cyc + 1 - a_start;
      e_gnt = '0; e_done = '0; e_busy = 1'b0; e_rd = 1'b0; e_wr = 1'b0;
      e_addr = m_addr; e_wdata = m_wdata; e_rdata = m_rdata;
      if (a_valid) begin
         if (d >= 1 && d <= L) begin e_rd = !a_wr; e_wr = a_wr; end
         if (d >= 1 && d <= L + 1) begin e_gnt = N'(1) << a_id; e_busy = 1'b1; end
         if (d == L + 1) e_done = N'(1) << a_id;
         if (!a_wr && d >= L + 1) e_rdata = a_rdata;
      end
      exp_vec = {e_gnt, e_done, e_busy, e_rd, e_wr, e_addr, e_wdata, e_rdata};
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   function automatic int gidx(input logic [N-1:0] g);
      int r;
      r = -1;
      for (int k = 0; k < N; k++) if (g[k]) r = k;
      return r;
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step();
         checks++;
         if (obs !== exp_vec) begin
            failures++; $display("FAIL reset cyc=%0d got=%h want=%h", cyc, obs, exp_vec);
         end
      end
      rst = 1'b0;
   endtask

   task automatic test_single_read();
      int n_done, n_rd;
      n_done = 0; n_rd = 0;
      mem[8'h10] = 8'hA5;
      req_rd[0] = 1'b1; req_addr[0 +: AW] = 16'h0010;
      for (int i = 0; i < 8; i++) begin
         step();
         checks++;
         if (obs !== exp_vec) begin
            failures++; $display("FAIL single_read cyc=%0d got=%h want=%h", cyc, obs, exp_vec);
         end
         if (mem_rd) begin
            n_rd++;
            checks++;
            if (mem_addr !== 16'h0010) begin
               failures++; $display("FAIL single_read_addr got=%h want=0010", mem_addr);
            end
         end
         if (done[0]) begin n_done++; req_rd[0] = 1'b0; end
      end
      checks++; if (n_done != 1) begin failures++; $display("FAIL single_read_done got=%0d want=1", n_done); end
      checks++; if (n_rd != L) begin failures++; $display("FAIL single_read_strobe got=%0d want=%0d", n_rd, L); end
      checks++; if (rdata !== 8'hA5) begin failures++; $display("FAIL single_read_rdata got=%h want=a5", rdata); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_read_busy got=%b want=0", busy); end
   endtask

   task automatic test_all_read();
      int order[$];
      int done_cyc[$];
      logic [N-1:0] prev;
      pulse_reset();
      for (int i = 0; i < N; i++) begin
         req_rd[i] = 1'b1; req_addr[i*AW +: AW] = 16'h0020 + AW'(i);
      end
      prev = '0;
      for (int i = 0; i < 24; i++) begin
         step();
         checks++;
         if (obs !== exp_vec) begin
            failures++; $display("FAIL all_read cyc=%0d got=%h want=%h", cyc, obs, exp_vec);
         end
         checks++;
         if ($countones(gnt) > 1) begin failures++; $display("FAIL all_read_onehot got=%b want<=1hot", gnt); end
         if (gnt != '0 && prev == '0) order.push_back(gidx(gnt));
         prev = gnt;
         if (done != '0) begin
            done_cyc.push_back(cyc);
            req_rd = req_rd & ~done;
         end
      end
      checks++;
      if (order.size() != N) begin failures++; $display("FAIL all_read_ngrants got=%0d want=%0d", order.size(), N); end
      for (int i = 0; i < order.size() && i < N; i++) begin
         checks++;
         if (order[i] != i) begin failures++; $display("FAIL all_read_order[%0d] got=%0d want=%0d", i, order[i], i); end
      end
      for (int i = 1; i < done_cyc.size(); i++) begin
         checks++;
         if (done_cyc[i] - done_cyc[i-1] != L + 2)
            begin failures++; $display("FAIL all_read_spacing got=%0d want=%0d", done_cyc[i] - done_cyc[i-1], L + 2); end
      end
   endtask

   task automatic test_write();
      int n_wr, n_rd, n_done;
      n_wr = 0; n_rd = 0; n_done = 0;
      req_wr[3] = 1'b1; req_addr[3*AW +: AW] = 16'h00FF; req_wdata[3*DW +: DW] = 8'h3C;
      for (int i = 0; i < 8; i++) begin
         step();
         checks++;
         if (obs !== exp_vec) begin
            failures++; $display("FAIL write cyc=%0d got=%h want=%h", cyc, obs, exp_vec);
         end
         if (mem_wr) begin
            n_wr++;
            checks++;
            if (mem_wdata !== 8'h3C || mem_addr !== 16'h00FF) begin
               failures++; $display("FAIL write_data got=%h/%h want=00ff/3c", mem_addr, mem_wdata);
            end
         end
         if (mem_rd) n_rd++;
         if (done[3]) begin n_done++; req_wr[3] = 1'b0; end
      end
      checks++; if (n_wr != L) begin failures++; $display("FAIL write_strobe got=%0d want=%0d", n_wr, L); end
      checks++; if (n_rd != 0) begin failures++; $display("FAIL write_rd got=%0d want=0", n_rd); end
      checks++; if (n_done != 1) begin failures++; $display("FAIL write_done got=%0d want=1", n_done); end
      checks++; if (rdata !== mem[8'h23]) begin failures++; $display("FAIL write_rdata got=%h want=%h", rdata, mem[8'h23]); end
   endtask

   task automatic test_hold_past_done();
      int order[$];
      int c1_done;
      logic [N-1:0] prev;
      pulse_reset();
      c1_done = 0; prev = '0;
      req_rd[1] = 1'b1; req_addr[1*AW +: AW] = 16'h0031;
      req_rd[2] = 1'b1; req_addr[2*AW +: AW] = 16'h0032;
      for (int i = 0; i < 20; i++) begin
         step();
         checks++;
         if (obs !== exp_vec) begin
            failures++; $display("FAIL hold cyc=%0d got=%h want=%h", cyc, obs, exp_vec);
         end
         if (gnt != '0 && prev == '0) order.push_back(gidx(gnt));
         prev = gnt;
         if (done[1]) begin c1_done++; if (c1_done == 2) req_rd[1] = 1'b0; end
         if (done[2]) req_rd[2] = 1'b0;
      end
      checks++;
      if (order.size() != 3) begin
         failures++; $display("FAIL hold_ngrants got=%0d want=3", order.size());
      end else begin
         checks++;
         if (order[0] != 1 || order[1] != 2 || order[2] != 1) begin
            failures++; $display("FAIL hold_order got=%0d,%0d,%0d want=1,2,1", order[0], order[1], order[2]);
         end
      end
   endtask

   task automatic test_reset_mid_access();
      int first, n_done0;
      pulse_reset();
      req_rd[1] = 1'b1; req_addr[1*AW +: AW] = 16'h0041;
      for (int i = 0; i < 6; i++) begin
         step();
         checks++;
         if (obs !== exp_vec) begin
            failures++; $display("FAIL rstmid_pre cyc=%0d got=%h want=%h", cyc, obs, exp_vec);
         end
         if (done[1]) req_rd[1] = 1'b0;
      end
      req_rd[0] = 1'b1; req_addr[0 +: AW] = 16'h0040;
      step();
      checks++;
      if (gnt !== 4'b0001 || mem_rd !== 1'b1) begin
         failures++; $display("FAIL rstmid_grant got=%b/%b want=0001/1", gnt, mem_rd);
      end
      rst = 1'b1; req_rd[2] = 1'b1; req_addr[2*AW +: AW] = 16'h0042;
      step();
      rst = 1'b0;
      checks++;
      if (mem_rd !== 1'b0 || gnt !== '0 || done !== '0) begin
         failures++; $display("FAIL rstmid_abort got=%b/%b/%b want=0/0000/0000", mem_rd, gnt, done);
      end
      first = -1; n_done0 = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         checks++;
         if (obs !== exp_vec) begin
            failures++; $display("FAIL rstmid_post cyc=%0d got=%h want=%h", cyc, obs, exp_vec);
         end
         if (first < 0 && gnt != '0) first = gidx(gnt);
         if (i < 2 && done[0]) n_done0++;
         if (done[0]) req_rd[0] = 1'b0;
         if (done[2]) req_rd[2] = 1'b0;
      end
      checks++; if (first != 0) begin failures++; $display("FAIL rstmid_first got=%0d want=0", first); end
      checks++; if (n_done0 != 0) begin failures++; $display("FAIL rstmid_stale_done got=%0d want=0", n_done0); end
   endtask

   task automatic test_both_bits();
      int n_wr, n_rd, n_done;
      n_wr = 0; n_rd = 0; n_done = 0;
      req_rd[2] = 1'b1; req_wr[2] = 1'b1;
      req_addr[2*AW +: AW] = 16'h0052; req_wdata[2*DW +: DW] = 8'h77;
      for (int i = 0; i < 8; i++) begin
         step();
         checks++;
         if (obs !== exp_vec) begin
            failures++; $display("FAIL both_bits cyc=%0d got=%h want=%h", cyc, obs, exp_vec);
         end
         if (mem_wr) n_wr++;
         if (mem_rd) n_rd++;
         if (done[2]) begin n_done++; req_rd[2] = 1'b0; req_wr[2] = 1'b0; end
      end
      checks++; if (n_wr != L) begin failures++; $display("FAIL both_bits_wr got=%0d want=%0d", n_wr, L); end
      checks++; if (n_rd != 0) begin failures++; $display("FAIL both_bits_rd got=%0d want=0", n_rd); end
      checks++; if (n_done != 1) begin failures++; $display("FAIL both_bits_done got=%0d want=1", n_done); end
   endtask

   task automatic test_random();
      int hold [N];
      int op;
      for (int i = 0; i < N; i++) hold[i] = 0;
      for (int c = 0; c < 800; c++) begin
         for (int i = 0; i < N; i++) begin
            if (hold[i] == 1) begin
               req_rd[i] = 1'b0; req_wr[i] = 1'b0; hold[i] = 0;
            end else if (hold[i] > 1) begin
               hold[i]--;
            end else if (!(req_rd[i] || req_wr[i]) && $urandom_range(3) == 0) begin
               op = $urandom_range(2);
               req_rd[i] = (op != 1); req_wr[i] = (op != 0);
               req_addr[i*AW +: AW] = AW'($urandom);
               req_wdata[i*DW +: DW] = DW'($urandom);
            end
            if ($urandom_range(7) == 0) req_addr[i*AW +: AW] = AW'($urandom);
            if ($urandom_range(7) == 0) req_wdata[i*DW +: DW] = DW'($urandom);
         end
         rst = ($urandom_range(99) == 0);
         step();
         checks++;
         if (obs !== exp_vec) begin
            failures++; $display("FAIL random cyc=%0d got=%h want=%h", cyc, obs, exp_vec);
         end
         for (int i = 0; i < N; i++) begin
            if (done[i]) begin
               if ($urandom_range(1) == 1) hold[i] = 2;
               else begin req_rd[i] = 1'b0; req_wr[i] = 1'b0; end
            end
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; req_rd = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      test_reset();
      test_single_read();
      test_all_read();
      test_write();
      test_hold_past_done();
      test_reset_mid_access();
      test_both_bits();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
